// File: rtl/requant_group_scheduler_pkg.sv
// Shared widths, limits and FSM encoding for the requant group scheduler.
// Contents:
//   QUANT_WIDTH, MAX_GROUPS  accumulator width and groups per packed word
//   GCNT_W, GIDX_W           group-count field width, group-index width
//   IDX_WIDTH_DEF            default output element index width
//   CREDITS_DEF              default number of downstream buffer slots
//   NG_MAX                   MAX_GROUPS at group-count field width
//   state_t                  scheduler FSM encoding (IDLE=0, ISSUE=1)
//   group_vec_t              packed word viewed as an array of groups
package requant_group_scheduler_pkg;

    localparam int QUANT_WIDTH   = 32;
    localparam int MAX_GROUPS    = 8;
    localparam int GCNT_W        = $clog2(MAX_GROUPS + 1);
    localparam int GIDX_W        = $clog2(MAX_GROUPS);
    localparam int IDX_WIDTH_DEF = 18;
    localparam int CREDITS_DEF   = 4;

    localparam logic [GCNT_W-1:0] NG_MAX = GCNT_W'(MAX_GROUPS);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef logic [MAX_GROUPS-1:0][QUANT_WIDTH-1:0] group_vec_t;

endpackage

// File: rtl/requant_group_scheduler_credit.sv
// rq_credit_counter: tracks free slots in a downstream buffer that cannot
// push back. Each issue consumes a slot and each credit_ret frees one.
// Ports:
//   clk, rst     clock, synchronous active-high reset (credits -> CREDITS)
//   issue        one slot consumed this cycle (caller only issues when credits!=0)
//   credit_ret   one slot freed this cycle
//   credits      current free slots
//   ovf          credit_ret with the counter already full and no issue
//                alongside (return ignored); one-cycle combinational flag
module rq_credit_counter #(
    parameter int CREDITS = 4,
    parameter int CRED_W  = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              credit_ret,
    output logic [CRED_W-1:0] credits,
    output logic              ovf
);

    logic full;

    assign full = (credits == CRED_W'(CREDITS));
    assign ovf  = credit_ret && !issue && full;

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CRED_W'(CREDITS);
        end else begin
            case ({issue, credit_ret})
                2'b10:   credits <= credits - CRED_W'(1);
                2'b01:   if (!full) credits <= credits + CRED_W'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: rtl/requant_group_scheduler.sv
// requant_group_scheduler: unpacks MAC-output FIFO words (num_groups plus up
// to MAX_GROUPS accumulators) and feeds the requantizer one group per cycle,
// gated by downstream credits since the requantizer cannot stall.
// Optional feature: define REQUANT_BIAS_EN to add the in_bias port; each
// group is then sent as data[g] + bias[g] (wrapping add).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   layer_start    clears out_idx and sticky errors
//   in_valid       FIFO word available
//   in_ready       word consumed this cycle (FIFO read strobe)
//   in_num_groups  valid groups in the word
//   in_data        group g at [g*QUANT_WIDTH +: QUANT_WIDTH]
//   in_bias        (REQUANT_BIAS_EN only) per-group bias, same layout
//   rq_valid, rq_x requantizer input strobe and value
//   rq_done        requantizer output strobe
//   credit_ret     downstream freed one slot
//   out_idx        index of next requantized element
//   busy           FSM active or credits outstanding
//   err_zero       sticky: word with num_groups==0 dropped
//   err_ovf        sticky: num_groups clamped or credit returned while full
//
// state | meaning
// IDLE  | no word held; in_ready high
// ISSUE | word held; issuing groups as credits allow, in_ready on last group
module requant_group_scheduler
    import requant_group_scheduler_pkg::*;
#(
    parameter int IDX_WIDTH = IDX_WIDTH_DEF,
    parameter int CREDITS   = CREDITS_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              layer_start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [GCNT_W-1:0]                 in_num_groups,
    input  logic [QUANT_WIDTH*MAX_GROUPS-1:0] in_data,
`ifdef REQUANT_BIAS_EN
    input  logic [QUANT_WIDTH*MAX_GROUPS-1:0] in_bias,
`endif
    output logic                              rq_valid,
    output logic [QUANT_WIDTH-1:0]            rq_x,
    input  logic                              rq_done,
    input  logic                              credit_ret,
    output logic [IDX_WIDTH-1:0]              out_idx,
    output logic                              busy,
    output logic                              err_zero,
    output logic                              err_ovf
);

    localparam int CRED_W = $clog2(CREDITS + 1);

    state_t              state, state_nxt;
    group_vec_t          data_q;
    logic [GCNT_W-1:0]   ng_q;
    logic [GIDX_W-1:0]   gcnt;
    logic [CRED_W-1:0]   credits;
    logic                cred_ovf;
    logic                issue, last, take, load;
    logic                in_zero, in_big;
    logic [GCNT_W-1:0]   ng_in;
    logic [QUANT_WIDTH-1:0] group_value;

    assign in_zero = (in_num_groups == '0);
    assign in_big  = (in_num_groups > NG_MAX);
    assign ng_in   = in_big ? NG_MAX : in_num_groups;
    assign last    = ((GCNT_W'(gcnt) + GCNT_W'(1)) == ng_q);
    assign take    = in_valid && in_ready;
    assign load    = take && !in_zero;

`ifdef REQUANT_BIAS_EN
    group_vec_t bias_q;
    assign group_value = data_q[gcnt] + bias_q[gcnt];
`else
    assign group_value = data_q[gcnt];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = ISSUE;
            ISSUE:   if (issue && last) state_nxt = load ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is held low during reset so the FIFO is never popped then.
    always_comb begin
        in_ready = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            ISSUE: begin
                issue    = (credits != '0);
                in_ready = issue && last;
            end
            default: ;
        endcase
        if (rst) in_ready = 1'b0;
    end

    // A load on the last-group cycle overrides the gcnt increment, giving a
    // gap-free handover to the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            ng_q     <= '0;
            gcnt     <= '0;
            rq_valid <= 1'b0;
            rq_x     <= '0;
        end else begin
            rq_valid <= issue;
            if (issue) begin
                rq_x <= group_value;
                gcnt <= gcnt + GIDX_W'(1);
            end
            if (load) begin
                data_q <= in_data;
                ng_q   <= ng_in;
                gcnt   <= '0;
            end
        end
    end

`ifdef REQUANT_BIAS_EN
    always_ff @(posedge clk) begin
        if (rst)       bias_q <= '0;
        else if (load) bias_q <= in_bias;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_idx  <= '0;
            err_zero <= 1'b0;
            err_ovf  <= 1'b0;
        end else begin
            if (layer_start) out_idx <= rq_done ? IDX_WIDTH'(1) : '0;
            else             out_idx <= out_idx + IDX_WIDTH'(rq_done);
            err_zero <= (err_zero && !layer_start) || (take && in_zero);
            err_ovf  <= (err_ovf && !layer_start) || (take && in_big) || cred_ovf;
        end
    end

    rq_credit_counter #(
        .CREDITS (CREDITS),
        .CRED_W  (CRED_W)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .credit_ret (credit_ret),
        .credits    (credits),
        .ovf        (cred_ovf)
    );

    assign busy = (state != IDLE) || (credits != CRED_W'(CREDITS));

endmodule

// File: tb/tb_requant_group_scheduler.sv
module tb_requant_group_scheduler;
    import requant_group_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst, layer_start, in_valid, rq_done, credit_ret;
    logic [GCNT_W-1:0] in_num_groups;
    logic [QUANT_WIDTH*MAX_GROUPS-1:0] in_data;
`ifdef REQUANT_BIAS_EN
    logic [QUANT_WIDTH*MAX_GROUPS-1:0] in_bias;
`endif
    logic in_ready, rq_valid, busy, err_zero, err_ovf;
    logic [QUANT_WIDTH-1:0] rq_x;
    logic [17:0] out_idx;
    logic s_in_ready, s_rq_valid, s_busy, s_err_zero, s_err_ovf;
    logic [QUANT_WIDTH-1:0] s_rq_x;
    logic [4:0] s_out_idx;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    requant_group_scheduler dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_num_groups(in_num_groups), .in_data(in_data),
`ifdef REQUANT_BIAS_EN
        .in_bias(in_bias),
`endif
        .rq_valid(rq_valid), .rq_x(rq_x), .rq_done(rq_done), .credit_ret(credit_ret),
        .out_idx(out_idx), .busy(busy), .err_zero(err_zero), .err_ovf(err_ovf)
    );

    // narrow-index instance so the out_idx wrap is reachable in a short run
    requant_group_scheduler #(.IDX_WIDTH(5)) dut_s (
        .clk(clk), .rst(rst), .layer_start(layer_start), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_num_groups(in_num_groups), .in_data(in_data),
`ifdef REQUANT_BIAS_EN
        .in_bias(in_bias),
`endif
        .rq_valid(s_rq_valid), .rq_x(s_rq_x), .rq_done(rq_done), .credit_ret(credit_ret),
        .out_idx(s_out_idx), .busy(s_busy), .err_zero(s_err_zero), .err_ovf(s_err_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int ng, input bit push);
        logic [31:0] d, b;
        int n;
        n = (ng > MAX_GROUPS) ? MAX_GROUPS : ng;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            d = $urandom;
            b = '0;
`ifdef REQUANT_BIAS_EN
            b = $urandom;
            in_bias[g*QUANT_WIDTH +: QUANT_WIDTH] = b;
`endif
            in_data[g*QUANT_WIDTH +: QUANT_WIDTH] = d;
            if (push && g < n) exp_q.push_back(d + b);
        end
        in_num_groups = GCNT_W'(ng);
        in_valid = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && rq_valid) begin
            if (exp_q.size() == 0) chk("rq_unexpected", 64'(exp_q.size()), 1);
            else                   chk("rq_x", rq_x, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; layer_start = 1'b0; in_valid = 1'b0; rq_done = 1'b0;
        credit_ret = 1'b0; in_num_groups = '0; in_data = '0;
`ifdef REQUANT_BIAS_EN
        in_bias = '0;
`endif
        repeat (3) step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rq_valid", rq_valid, 0);
        chk("rst_rq_x", rq_x, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_zero", err_zero, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("idle_in_ready", in_ready, 1);

        // single word, three groups, no credit returns
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 0) put_word(3, 1);
            if (k == 1) in_valid = 1'b0;
            @(negedge clk);
            chk("t1_valid", rq_valid, (k >= 2 && k <= 4));
            if (k == 1) chk("t1_in_ready", in_ready, 0);
        end
        chk("t1_credits", dut.credits, 1);
        chk("t1_busy", busy, 1);
        step(); credit_ret = 1'b1;
        step(); step(); step();
        credit_ret = 1'b0;
        @(negedge clk);
        chk("t1_busy_end", busy, 0);
        chk("t1_credits_end", dut.credits, 4);
        chk("t1_drain", 64'(exp_q.size()), 0);

        // two back-to-back words with a credit returned every cycle
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 0) put_word(2, 1);
            if (k == 1) put_word(2, 1);
            if (k == 2) credit_ret = 1'b1;
            if (k == 3) in_valid = 1'b0;
            if (k == 6) credit_ret = 1'b0;
            @(negedge clk);
            chk("t2_valid", rq_valid, (k >= 2 && k <= 5));
            if (k == 1) chk("t2_ready_mid", in_ready, 0);
            if (k == 2) chk("t2_ready_last", in_ready, 1);
        end
        chk("t2_credits", dut.credits, 4);
        chk("t2_err_ovf", err_ovf, 0);
        chk("t2_drain", 64'(exp_q.size()), 0);

        // eight groups, credits run out, single return releases one issue
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 0) put_word(8, 1);
            if (k == 1) in_valid = 1'b0;
            if (k == 8) credit_ret = 1'b1;
            if (k == 9) credit_ret = 1'b0;
            @(negedge clk);
            chk("t3_valid", rq_valid, ((k >= 2 && k <= 5) || k == 10));
        end
        chk("t3_left", 64'(exp_q.size()), 3);
        chk("t3_state", dut.state, ISSUE);
        step(); rst = 1'b1;
        step();
        @(negedge clk);
        chk("t3_rst_valid", rq_valid, 0);
        chk("t3_rst_state", dut.state, IDLE);
        exp_q.delete();
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t3_rst_busy", busy, 0);
        chk("t3_rst_ready", in_ready, 1);

        // num_groups above MAX_GROUPS is clamped
        for (int k = 0; k <= 11; k++) begin
            step();
            if (k == 0) put_word(9, 1);
            if (k == 1) in_valid = 1'b0;
            if (k == 2) credit_ret = 1'b1;
            if (k == 10) credit_ret = 1'b0;
            @(negedge clk);
            chk("t4_valid", rq_valid, (k >= 2 && k <= 9));
        end
        chk("t4_err_ovf", err_ovf, 1);
        chk("t4_credits", dut.credits, 4);
        chk("t4_drain", 64'(exp_q.size()), 0);

        // zero-group word is dropped
        step(); put_word(0, 0);
        @(negedge clk);
        chk("t5_in_ready", in_ready, 1);
        step(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_no_valid", rq_valid, 0);
            step();
        end
        chk("t5_err_zero", err_zero, 1);
        chk("t5_busy", busy, 0);
        layer_start = 1'b1;
        step(); layer_start = 1'b0;
        @(negedge clk);
        chk("t5_clr_zero", err_zero, 0);
        chk("t5_clr_ovf", err_ovf, 0);
        chk("t5_out_idx", out_idx, 0);

        // out_idx counting and layer_start interaction
        step(); rq_done = 1'b1;
        step(); step(); step();
        rq_done = 1'b0;
        @(negedge clk);
        chk("t6_idx3", out_idx, 3);
        step(); layer_start = 1'b1; rq_done = 1'b1;
        step(); layer_start = 1'b0; rq_done = 1'b0;
        @(negedge clk);
        chk("t6_idx_ls_done", out_idx, 1);
        step(); layer_start = 1'b1;
        step(); layer_start = 1'b0;
        @(negedge clk);
        chk("t6_idx_ls", out_idx, 0);

        // credit return while already full
        step(); credit_ret = 1'b1;
        step(); credit_ret = 1'b0;
        @(negedge clk);
        chk("t6_cred_ovf", err_ovf, 1);
        chk("t6_cred_busy", busy, 0);
        chk("t6_cred_cnt", dut.credits, 4);
        step(); layer_start = 1'b1;
        step(); layer_start = 1'b0;

        // out_idx wrap on the narrow instance
        rq_done = 1'b1;
        repeat (31) step();
        @(negedge clk);
        chk("t7_idx31", s_out_idx, 31);
        step(); rq_done = 1'b0;
        @(negedge clk);
        chk("t7_wrap", s_out_idx, 0);
        chk("t7_main_idx", out_idx, 32);

`ifdef REQUANT_BIAS_EN
        step();
        in_data = '0; in_bias = '0;
        in_data[31:0] = 32'h7FFF_FFFF;
        in_bias[31:0] = 32'h0000_0001;
        in_num_groups = GCNT_W'(1);
        in_valid = 1'b1;
        exp_q.push_back(32'h8000_0000);
        step(); in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("t8_bias_drain", 64'(exp_q.size()), 0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
